// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mult_pkg;

  localparam int MULT_N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_ctrl.sv
// Control FSM for seq_shift_add_mult: IDLE -> (RUN ->) DONE -> IDLE.
// finish marks the edge that enters DONE, used for the final sign fix-up.
module mult_ctrl
  import mult_pkg::*;
(
  input  logic clk,
  input  logic clr_n,
  input  logic start,
  input  logic b_zero,
  input  logic rb_next_zero,
  output logic load,
  output logic step,
  output logic busy,
  output logic done,
  output logic finish
);

  mult_state_t state_q, state_d;

  // state register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state: a zero multiplier skips RUN entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = b_zero ? DONE : RUN;
      RUN:     if (rb_next_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs: start only matters in IDLE, so busy cycles ignore it
  always_comb begin
    load   = (state_q == IDLE) && start;
    step   = (state_q == RUN);
    busy   = (state_q == RUN) || (state_q == DONE);
    done   = (state_q == DONE);
    finish = (load && b_zero) || (step && rb_next_zero);
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential N x N -> 2N shift-and-add multiplier with early termination.
// Optional build macro MULT_SIGNED_EN adds signed_op (two's complement via
// magnitude multiply plus a negate on the finishing edge).
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int N = MULT_N_DEF
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
`ifdef MULT_SIGNED_EN
  input  logic           signed_op,
`endif
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  logic [2*N-1:0] ra;
  logic [N-1:0]   rb;
  logic [N-1:0]   a_mag, b_mag;
  logic [2*N-1:0] p_nxt;
  logic           load, step, finish;
  logic           b_zero, rb_next_zero;

  assign b_zero       = (b == '0);
  assign rb_next_zero = (rb[N-1:1] == '0);
  assign p_nxt        = rb[0] ? (p + ra) : p;

  mult_ctrl u_ctrl (
    .clk          (clk),
    .clr_n        (clr_n),
    .start        (start),
    .b_zero       (b_zero),
    .rb_next_zero (rb_next_zero),
    .load         (load),
    .step         (step),
    .busy         (busy),
    .done         (done),
    .finish       (finish)
  );

`ifdef MULT_SIGNED_EN
  logic neg, neg_in;

  // operand magnitudes; -2^(N-1) maps to 2^(N-1), which still fits unsigned
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    neg_in = 1'b0;
    if (signed_op) begin
      if (a[N-1]) a_mag = -a;
      if (b[N-1]) b_mag = -b;
      neg_in = a[N-1] ^ b[N-1];
    end
  end

  // datapath: load, shift/accumulate, negate on the last step if needed
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ra  <= '0;
      rb  <= '0;
      p   <= '0;
      neg <= 1'b0;
    end else if (load) begin
      ra  <= {{N{1'b0}}, a_mag};
      rb  <= b_mag;
      p   <= '0;
      neg <= neg_in;
    end else if (step) begin
      ra <= ra << 1;
      rb <= rb >> 1;
      if (finish) p <= neg ? -p_nxt : p_nxt;
      else        p <= p_nxt;
    end
  end
`else
  assign a_mag = a;
  assign b_mag = b;

  // datapath: load, then shift/accumulate one multiplier bit per RUN cycle
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ra <= '0;
      rb <= '0;
      p  <= '0;
    end else if (load) begin
      ra <= {{N{1'b0}}, a_mag};
      rb <= b_mag;
      p  <= '0;
    end else if (step) begin
      ra <= ra << 1;
      rb <= rb >> 1;
      p  <= p_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult (N=4 main instance, N=8 side instance).
module tb_seq_shift_add_mult;

  logic       clk = 1'b0;
  logic       clr_n, start, sop;
  logic [3:0] a, b;
  logic       busy, done;
  logic [7:0] p;

  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8;
  logic [15:0] p8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { logic [7:0] p; int lat; int acc; } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_shift_add_mult #(.N(4)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .a(a), .b(b),
`ifdef MULT_SIGNED_EN
    .signed_op(sop),
`endif
    .busy(busy), .done(done), .p(p)
  );

  seq_shift_add_mult #(.N(8)) dut8 (
    .clk(clk), .clr_n(clr_n), .start(start8), .a(a8), .b(b8),
`ifdef MULT_SIGNED_EN
    .signed_op(1'b0),
`endif
    .busy(busy8), .done(done8), .p(p8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mdl(input logic [3:0] x, input logic [3:0] y, input logic s);
    logic signed [7:0] sx, sy;
    sx = {{4{x[3]}}, x};
    sy = {{4{y[3]}}, y};
    if (s) return 8'(sx * sy);
    return 8'({4'b0, x} * {4'b0, y});
  endfunction

  function automatic int lat_of(input logic [3:0] y, input logic s);
    logic [3:0] m;
    int l;
    m = (s && y[3]) ? 4'(0 - y) : y;
    l = 0;
    for (int i = 0; i < 4; i++) if (m[i]) l = i + 1;
    return l;
  endfunction

  // scoreboard: every done pulse must match the oldest outstanding op
  always @(negedge clk) begin
    if (clr_n && done) begin
      if (sbq.size() == 0) chk("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("p", p, e.p);
        chk("latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic s, input bit mid);
    exp_t e;
    int nb;
    bit got;
    @(negedge clk);
    a = x; b = y; sop = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.p = mdl(x, y, s); e.lat = lat_of(y, s); e.acc = cyc;
    sbq.push_back(e);
    nb = 0; got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mid && k == 1) begin start = 1'b1; a = 4'd1; b = 4'd1; end
      if (mid && k == 2) start = 1'b0;
      if (busy) nb++;
      if (done) begin got = 1; break; end
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 1);
    chk("busy_cycles", nb, e.lat + 1);
    repeat (3) @(negedge clk);
    chk("p_hold", p, e.p);
  endtask

  initial begin
    int acc8;
    bit got8;
    clr_n = 1'b0; start = 1'b0; sop = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_p", p, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    clr_n = 1'b1;

    run_op(4'd13, 4'd11, 1'b0, 1'b0);   // 143, 4 RUN cycles
    run_op(4'd15, 4'd0,  1'b0, 1'b0);   // b=0 skips RUN
    run_op(4'd9,  4'd1,  1'b0, 1'b0);   // single RUN cycle
    run_op(4'd15, 4'd15, 1'b0, 1'b1);   // 225, start pulsed mid-RUN

    // reset in the 2nd RUN cycle
    @(negedge clk);
    a = 4'd15; b = 4'd15; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #2;
    clr_n = 1'b0;
    #1;
    chk("midrst_p", p, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk); clr_n = 1'b1;
    run_op(4'd6, 4'd7, 1'b0, 1'b0);     // 42

    for (int i = 0; i < 6; i++)
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);

`ifdef MULT_SIGNED_EN
    run_op(4'b1000, 4'b1000, 1'b1, 1'b0);  // 64
    run_op(4'b1101, 4'd5,    1'b1, 1'b0);  // 8'hF1
    run_op(4'b1111, 4'd0,    1'b1, 1'b0);  // 0
    for (int i = 0; i < 6; i++)
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
`endif

    // N=8 worst case: 8 RUN cycles
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    acc8 = cyc; got8 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done8) begin got8 = 1; break; end
    end
    chk("n8_done_seen", 32'(got8), 1);
    chk("n8_p", p8, 16'd65025);
    chk("n8_latency", cyc - acc8, 8);

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
